// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin grant among functional units, winner
// broadcast on a registered CDB one cycle after acceptance.

module cdb_arb_lane #(
  parameter int                   UNIT_SIZE = 8,
  parameter logic [UNIT_SIZE-1:0] READY_TAG = 8'h7F
) (
  input  logic [UNIT_SIZE-1:0] tag_i,
  output logic                 rsv_o
);
  assign rsv_o = (tag_i == READY_TAG);
endmodule

module cdb_arbiter #(
  parameter int                   N_REQ     = 4,
  parameter int                   WORD_SIZE = 32,
  parameter int                   UNIT_SIZE = 8,
  parameter logic [UNIT_SIZE-1:0] READY_TAG = 8'h7F
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [N_REQ*UNIT_SIZE-1:0]   req_tag,
  input  logic [N_REQ*WORD_SIZE-1:0]   req_data,
  output logic [N_REQ-1:0]             req_ready,
  output logic                         cdb_valid,
  output logic [UNIT_SIZE-1:0]         cdb_tag,
  output logic [WORD_SIZE-1:0]         cdb_data,
  output logic [15:0]                  cdb_count,
  output logic                         err_tag
);
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0][UNIT_SIZE-1:0] lane_tag;
  logic [N_REQ-1:0][WORD_SIZE-1:0] lane_data;
  logic [N_REQ-1:0]                lane_rsv;

  for (genvar g = 0; g < N_REQ; g++) begin : g_lane
    assign lane_tag[g]  = req_tag[g*UNIT_SIZE +: UNIT_SIZE];
    assign lane_data[g] = req_data[g*WORD_SIZE +: WORD_SIZE];
    cdb_arb_lane #(.UNIT_SIZE(UNIT_SIZE), .READY_TAG(READY_TAG)) u_lane (
      .tag_i (lane_tag[g]),
      .rsv_o (lane_rsv[g])
    );
  end

  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                 cdb_valid_q, cdb_valid_d;
  logic [UNIT_SIZE-1:0] cdb_tag_q, cdb_tag_d;
  logic [WORD_SIZE-1:0] cdb_data_q, cdb_data_d;
  logic [15:0]          cdb_count_q, cdb_count_d;
  logic                 err_tag_q, err_tag_d;

  logic [N_REQ-1:0]     grant;
  logic [PTR_W-1:0]     gnt_idx;
  logic [PTR_W:0]       idx;
  logic                 xfer;

  // Scan from rr_ptr upward with wrap; reset low also masks grants.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    idx     = '0;
    xfer    = 1'b0;
    if (rst_n && !flush) begin
      for (int k = 0; k < N_REQ; k++) begin
        idx = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
        if (idx >= (PTR_W+1)'(N_REQ)) idx = idx - (PTR_W+1)'(N_REQ);
        if (!xfer && req_valid[idx[PTR_W-1:0]]) begin
          xfer                     = 1'b1;
          grant[idx[PTR_W-1:0]]    = 1'b1;
          gnt_idx                  = idx[PTR_W-1:0];
        end
      end
    end
  end

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    cdb_valid_d = 1'b0;
    cdb_tag_d   = cdb_tag_q;
    cdb_data_d  = cdb_data_q;
    cdb_count_d = cdb_count_q;
    err_tag_d   = err_tag_q;
    if (xfer) begin
      rr_ptr_d = (gnt_idx == PTR_W'(N_REQ-1)) ? '0 : gnt_idx + PTR_W'(1);
      // Reserved tag is consumed but never reaches the bus.
      if (lane_rsv[gnt_idx]) begin
        err_tag_d = 1'b1;
      end else begin
        cdb_valid_d = 1'b1;
        cdb_tag_d   = lane_tag[gnt_idx];
        cdb_data_d  = lane_data[gnt_idx];
        cdb_count_d = cdb_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= READY_TAG;
      cdb_data_q  <= '0;
      cdb_count_q <= '0;
      err_tag_q   <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
      cdb_count_q <= cdb_count_d;
      err_tag_q   <= err_tag_d;
    end
  end

  assign req_ready = grant;
  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_data  = cdb_data_q;
  assign cdb_count = cdb_count_q;
  assign err_tag   = err_tag_q;
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Arbitrates the common data bus (CDB) between the functional units fed by the reservation stations: add, mul, load and mv.
- Each unit presents a completed result as a tag plus a value. The block grants one requester per cycle in round-robin order and broadcasts the winner on a registered CDB, one cycle after acceptance.
- The reservation stations and the register file snoop the CDB to resolve pending tags. The fetch/issue side has no direct connection to this block.

Parameters:
- N_REQ, 4, number of requesting functional units; index 0 = add, 1 = mul, 2 = load, 3 = mv.
- WORD_SIZE, 32, width of a result value.
- UNIT_SIZE, 8, width of a producer tag.
- READY_TAG, 8'h7F, reserved tag meaning "value present / no producer"; it is never broadcast.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- flush, input, 1, synchronous squash: no grants while high.
- req_valid, input, N_REQ, unit i holds a result.
- req_tag, input, N_REQ*UNIT_SIZE, packed tags; unit i occupies bits [i*UNIT_SIZE +: UNIT_SIZE].
- req_data, input, N_REQ*WORD_SIZE, packed signed results, packed the same way.
- req_ready, output, N_REQ, one-hot (or zero) grant; combinational.
- cdb_valid, output, 1, broadcast valid; registered.
- cdb_tag, output, UNIT_SIZE, broadcast tag; registered.
- cdb_data, output, WORD_SIZE, broadcast value; registered.
- cdb_count, output, 16, number of broadcasts issued; wraps.
- err_tag, output, 1, sticky flag: a request carried READY_TAG.

Behaviour:
- Reset (rst_n low, asynchronous):
  - cdb_valid=0, cdb_tag=READY_TAG, cdb_data=0, cdb_count=0, err_tag=0, rr_ptr=0.
  - req_ready is forced to 0 while rst_n is low.
- Handshake:
  - Unit i holds req_valid[i], req_tag and req_data stable until it samples req_ready[i]=1 at a rising edge.
  - Transfer occurs on the edge where req_valid[i] and req_ready[i] are both 1.
  - Units must not withdraw a request before transfer; flush is the only legal withdrawal path.
- Arbitration (combinational each cycle):
  - When flush=0, scan indices rr_ptr, rr_ptr+1, ... mod N_REQ.
  - The first i with req_valid[i]=1 gets req_ready[i]=1; all other ready bits are 0.
  - With no valid requests, or with flush=1, req_ready=0.
- Pointer update, on transfer of i: rr_ptr <= (i+1) mod N_REQ. With no transfer, rr_ptr holds.
- Broadcast, on the edge after transfer of i with tag != READY_TAG:
  - cdb_valid=1, cdb_tag=req_tag[i], cdb_data=req_data[i].
  - cdb_count increments by 1, wrapping 16'hFFFF -> 0.
  - Latency from acceptance to broadcast is exactly 1 cycle.
- Idle: with no transfer in a cycle, cdb_valid=0 next edge. cdb_tag and cdb_data hold their last values (don't-care when cdb_valid=0).
- Back-to-back: grants may occur every cycle, so cdb_valid may stay high across consecutive cycles with a different tag each cycle.
- Reserved tag: a request with tag == READY_TAG is accepted normally (ready asserted, pointer advances). It is not broadcast: cdb_valid=0 next cycle and cdb_count does not increment. err_tag is set to 1 and stays set until reset.
- Flush:
  - No grant occurs in a flush cycle; cdb_valid=0 on the following edge.
  - A broadcast already registered (the transfer was in the previous cycle) still appears in the cycle flush is high. It is not retracted.
  - rr_ptr, cdb_count and err_tag are unaffected by flush.
- Simultaneous events:
  - All N_REQ valid: grants rotate, so each unit is served within N_REQ cycles (starvation-free).
  - A unit that re-asserts valid immediately after its own transfer waits behind every other valid unit.
- Reset mid-operation: pending requests are dropped from the arbiter's view. Units re-present after reset, and no broadcast is generated for the interrupted cycle.

Test Plan:
- Single request: after reset, req_valid=4'b0010 with tag 8'h05 and data 32'd42 -> req_ready=4'b0010 in the same cycle; next cycle cdb_valid=1, cdb_tag=8'h05, cdb_data=42, cdb_count=1; rr_ptr=2.
- Full contention: all four valid with tags 8'h10..8'h13, held until accepted, rr_ptr=0 -> CDB tags 8'h10, 8'h11, 8'h12, 8'h13 on four consecutive cycles; cdb_valid high for 4 cycles, then 0.
- Wrap/fairness: rr_ptr=3 and units 0 and 3 valid -> unit 3 granted first, then unit 0; rr_ptr ends at 1.
- Reserved tag: unit 2 valid with tag 8'h7F -> accepted; cdb_valid stays 0 and cdb_count unchanged; err_tag=1 and remains 1 through 10 subsequent idle cycles.
- Flush:
  - Unit 1 valid with flush=1 for 3 cycles -> req_ready=0 and no broadcast.
  - On flush deassert, unit 1 is granted and broadcast 1 cycle later.
  - A grant in the cycle before flush still broadcasts.
- Async reset mid-burst: drop rst_n between clock edges during full contention -> cdb_valid, cdb_count, rr_ptr and err_tag all return to reset values immediately, with req_ready=0 while reset is low.
